// File: rtl/axilite_pkg.sv
// ============================================================================
// Module      : axilite_pkg
// Description : Shared AXI4-Lite response codes, FSM states and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Index ports need at least one bit even for a single-word bank
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axilite_addr_decode.sv
// ============================================================================
// Module      : axilite_addr_decode
// Description : Combinational AXI4-Lite byte address to {word index, response}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axilite_addr_decode
    import axilite_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_SIZE  = 32,
    parameter int                   NUM_REGS   = 4,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = '0,
    localparam int                  IDX_W      = idx_width(NUM_REGS)
) (
    input  logic [ADDR_SIZE-1:0] addr,
    output logic [IDX_W-1:0]     index,
    output logic [1:0]           resp
);

    localparam int                   ADDR_LSB   = clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_SIZE-1:0] NUM_REGS_A = ADDR_SIZE'(NUM_REGS);

    logic [ADDR_SIZE-1:0] w_off;
    logic [ADDR_SIZE-1:0] w_word_off;

    // Misalignment wins over range errors; the offset wraps at ADDR_SIZE
    always_comb begin
        w_off      = addr - BASE_ADDR;
        w_word_off = w_off >> ADDR_LSB;
        index      = '0;
        resp       = RESP_OKAY;
        if (w_off[ADDR_LSB-1:0] != '0) begin
            resp = RESP_SLVERR;
        end else if ((addr < BASE_ADDR) || (w_word_off >= NUM_REGS_A)) begin
            resp = RESP_DECERR;
        end else begin
            index = w_word_off[IDX_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/axilite_read_slave.sv
// ============================================================================
// Module      : axilite_read_slave
// Description : AXI4-Lite read slave over a flat register bank, one read in
//               flight. Optional AXIL_RD_PIPE_EN adds a FETCH cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axilite_read_slave
    import axilite_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_SIZE  = 32,
    parameter int                   NUM_REGS   = 4,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = '0,
    localparam int                  IDX_W      = idx_width(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_bank,
    input  logic [ADDR_SIZE-1:0]           araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [IDX_W-1:0]               rd_index,
    output logic                           rd_strobe
);

    state_t                r_state;
    state_t                w_state_n;
    logic                  r_arready;
    logic                  w_arready_n;
    logic                  r_rvalid;
    logic                  w_rvalid_n;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_n;
    logic [1:0]            r_rresp;
    logic [1:0]            w_rresp_n;
    logic                  r_strobe;
    logic                  w_strobe_n;
    logic [IDX_W-1:0]      r_index;
    logic [IDX_W-1:0]      w_index_n;

    logic [IDX_W-1:0]      w_dec_idx;
    logic [1:0]            w_dec_resp;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [DATA_WIDTH-1:0] w_sel_word;
    logic                  w_accept;

    logic [DATA_WIDTH-1:0] w_words [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_words
        assign w_words[i] = reg_bank[i*DATA_WIDTH +: DATA_WIDTH];
    end

    axilite_addr_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decode (
        .addr  (araddr),
        .index (w_dec_idx),
        .resp  (w_dec_resp)
    );

    assign w_accept = (r_state == IDLE) && r_arready && arvalid;

`ifdef AXIL_RD_PIPE_EN
    // Decode result is parked here so the wide word mux sits in its own cycle
    logic [IDX_W-1:0] r_fetch_idx;
    logic [IDX_W-1:0] w_fetch_idx_n;
    logic [1:0]       r_fetch_resp;
    logic [1:0]       w_fetch_resp_n;

    assign w_sel_idx = r_fetch_idx;
`else
    assign w_sel_idx = w_dec_idx;
`endif

    assign w_sel_word = w_words[w_sel_idx];

    always_comb begin
        w_state_n   = r_state;
        w_arready_n = r_arready;
        w_rvalid_n  = r_rvalid;
        w_rdata_n   = r_rdata;
        w_rresp_n   = r_rresp;
        w_strobe_n  = 1'b0;
        w_index_n   = r_index;
`ifdef AXIL_RD_PIPE_EN
        w_fetch_idx_n  = r_fetch_idx;
        w_fetch_resp_n = r_fetch_resp;
`endif
        case (r_state)
            IDLE: begin
                w_arready_n = 1'b1;
                if (w_accept) begin
                    w_arready_n = 1'b0;
                    if (w_dec_resp == RESP_OKAY) begin
                        w_strobe_n = 1'b1;
                        w_index_n  = w_dec_idx;
                    end
`ifdef AXIL_RD_PIPE_EN
                    w_state_n      = FETCH;
                    w_fetch_idx_n  = w_dec_idx;
                    w_fetch_resp_n = w_dec_resp;
`else
                    w_state_n  = RESP;
                    w_rvalid_n = 1'b1;
                    w_rresp_n  = w_dec_resp;
                    w_rdata_n  = (w_dec_resp == RESP_OKAY) ? w_sel_word : '0;
`endif
                end
            end
            FETCH: begin
`ifdef AXIL_RD_PIPE_EN
                w_state_n  = RESP;
                w_rvalid_n = 1'b1;
                w_rresp_n  = r_fetch_resp;
                w_rdata_n  = (r_fetch_resp == RESP_OKAY) ? w_sel_word : '0;
`else
                w_state_n  = IDLE;
`endif
            end
            RESP: begin
                if (rready) begin
                    w_state_n   = IDLE;
                    w_rvalid_n  = 1'b0;
                    w_arready_n = 1'b1;
                end
            end
            default: begin
                w_state_n   = IDLE;
                w_rvalid_n  = 1'b0;
                w_arready_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_strobe  <= 1'b0;
            r_index   <= '0;
        end else begin
            r_state   <= w_state_n;
            r_arready <= w_arready_n;
            r_rvalid  <= w_rvalid_n;
            r_rdata   <= w_rdata_n;
            r_rresp   <= w_rresp_n;
            r_strobe  <= w_strobe_n;
            r_index   <= w_index_n;
        end
    end

`ifdef AXIL_RD_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_idx  <= '0;
            r_fetch_resp <= RESP_OKAY;
        end else begin
            r_fetch_idx  <= w_fetch_idx_n;
            r_fetch_resp <= w_fetch_resp_n;
        end
    end
`endif

    assign arready   = r_arready;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign rresp     = r_rresp;
    assign rd_strobe = r_strobe;
    assign rd_index  = r_index;

endmodule

`default_nettype wire

// File: tb/tb_axilite_read_slave.sv
// ============================================================================
// Module      : tb_axilite_read_slave
// Description : Self-checking bench; three lockstep slaves (32b base 0,
//               32b base 0x100, 64b base 0) against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axilite_read_slave;

`ifdef AXIL_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    logic [31:0]  bank_a [4];
    logic [31:0]  bank_b [4];
    logic [63:0]  bank_c [4];
    logic [127:0] flat_a;
    logic [127:0] flat_b;
    logic [255:0] flat_c;

    always_comb begin
        flat_a = '0;
        flat_b = '0;
        flat_c = '0;
        for (int i = 0; i < 4; i++) begin
            flat_a[i*32 +: 32] = bank_a[i];
            flat_b[i*32 +: 32] = bank_b[i];
            flat_c[i*64 +: 64] = bank_c[i];
        end
    end

    logic        arready_a, arready_b, arready_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        strobe_a, strobe_b, strobe_c;
    logic [1:0]  rresp_a, rresp_b, rresp_c;
    logic [1:0]  idx_a, idx_b, idx_c;
    logic [31:0] rdata_a, rdata_b;
    logic [63:0] rdata_c;

    axilite_read_slave #(.DATA_WIDTH(32), .ADDR_SIZE(32), .NUM_REGS(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .reg_bank(flat_a), .araddr(araddr), .arvalid(arvalid),
        .arready(arready_a), .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a),
        .rready(rready), .rd_index(idx_a), .rd_strobe(strobe_a));

    axilite_read_slave #(.DATA_WIDTH(32), .ADDR_SIZE(32), .NUM_REGS(4), .BASE_ADDR(32'h100)) dut_b (
        .clk(clk), .rst(rst), .reg_bank(flat_b), .araddr(araddr), .arvalid(arvalid),
        .arready(arready_b), .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b),
        .rready(rready), .rd_index(idx_b), .rd_strobe(strobe_b));

    axilite_read_slave #(.DATA_WIDTH(64), .ADDR_SIZE(32), .NUM_REGS(4), .BASE_ADDR(32'h0)) dut_c (
        .clk(clk), .rst(rst), .reg_bank(flat_c), .araddr(araddr), .arvalid(arvalid),
        .arready(arready_c), .rdata(rdata_c), .rresp(rresp_c), .rvalid(rvalid_c),
        .rready(rready), .rd_index(idx_c), .rd_strobe(strobe_c));

    logic        arready_v [3];
    logic        rvalid_v  [3];
    logic        strobe_v  [3];
    logic [1:0]  rresp_v   [3];
    logic [1:0]  idx_v     [3];
    logic [63:0] rdata_v   [3];

    assign arready_v[0] = arready_a;  assign arready_v[1] = arready_b;  assign arready_v[2] = arready_c;
    assign rvalid_v[0]  = rvalid_a;   assign rvalid_v[1]  = rvalid_b;   assign rvalid_v[2]  = rvalid_c;
    assign strobe_v[0]  = strobe_a;   assign strobe_v[1]  = strobe_b;   assign strobe_v[2]  = strobe_c;
    assign rresp_v[0]   = rresp_a;    assign rresp_v[1]   = rresp_b;    assign rresp_v[2]   = rresp_c;
    assign idx_v[0]     = idx_a;      assign idx_v[1]     = idx_b;      assign idx_v[2]     = idx_c;
    assign rdata_v[0]   = {32'h0, rdata_a};
    assign rdata_v[1]   = {32'h0, rdata_b};
    assign rdata_v[2]   = rdata_c;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]  resp;
        logic [63:0] data;
        logic [1:0]  idx;
    } exp_t;

    // Reference: instance 0 = 32b@0, 1 = 32b@0x100, 2 = 64b@0
    function automatic exp_t model(input int k, input logic [31:0] addr);
        exp_t        e;
        logic [31:0] base;
        logic [31:0] bpw;
        logic [31:0] off;
        base   = (k == 1) ? 32'h100 : 32'h0;
        bpw    = (k == 2) ? 32'd8 : 32'd4;
        off    = addr - base;
        e.resp = 2'd0;
        e.data = '0;
        e.idx  = '0;
        if ((off % bpw) != 0) begin
            e.resp = 2'd2;
        end else if ((addr < base) || ((off / bpw) >= 32'd4)) begin
            e.resp = 2'd3;
        end else begin
            e.idx = 2'(off / bpw);
            if (k == 0)      e.data = {32'h0, bank_a[e.idx]};
            else if (k == 1) e.data = {32'h0, bank_b[e.idx]};
            else             e.data = bank_c[e.idx];
        end
        return e;
    endfunction

    logic [1:0]  cap_resp [3];
    logic [63:0] cap_data [3];

    // One complete read on all three slaves; hold = rready-low cycles in RESP
    task automatic do_read(input logic [31:0] addr, input int hold, input bit poke, input bit block_ar);
        exp_t e [3];
        int   cyc;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (hold == 0);
        cyc     = 0;
        while (arready_v[0] !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ar_accept_wait", 0, 64'(cyc < 20), 64'd1);
        for (int k = 0; k < 3; k++) e[k] = model(k, addr);
        @(posedge clk); #1;
        arvalid = block_ar;
        araddr  = '0;
        for (int k = 0; k < 3; k++) begin
            chk("strobe_on_accept", k, 64'(strobe_v[k]), 64'(e[k].resp == 2'd0));
            if (e[k].resp == 2'd0) chk("rd_index", k, 64'(idx_v[k]), 64'(e[k].idx));
            chk("arready_drop", k, 64'(arready_v[k]), 64'd0);
            chk("rvalid_n1", k, 64'(rvalid_v[k]), 64'(LAT == 1));
        end
        for (int w = 1; w < LAT; w++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            chk("rvalid", k, 64'(rvalid_v[k]), 64'd1);
            chk("rresp", k, 64'(rresp_v[k]), 64'(e[k].resp));
            chk("rdata", k, rdata_v[k], e[k].data);
            cap_resp[k] = rresp_v[k];
            cap_data[k] = rdata_v[k];
        end
        if (poke) begin
            bank_a[1] = 32'hDEADBEEF;
            bank_b[1] = ~bank_b[1];
            bank_c[1] = ~bank_c[1];
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                chk("hold_rvalid", k, 64'(rvalid_v[k]), 64'd1);
                chk("hold_rdata", k, rdata_v[k], e[k].data);
                chk("hold_rresp", k, 64'(rresp_v[k]), 64'(e[k].resp));
                chk("hold_arready", k, 64'(arready_v[k]), 64'd0);
                chk("hold_strobe", k, 64'(strobe_v[k]), 64'd0);
            end
        end
        rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rvalid", k, 64'(rvalid_v[k]), 64'd0);
            chk("post_arready", k, 64'(arready_v[k]), 64'd1);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp_a;
        logic [31:0] data_a;
        logic [1:0]  resp_b;
        logic [31:0] data_b;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h008, 2'd0, 32'h33333333, 2'd3, 32'h0};
        tbl[1] = '{32'h00C, 2'd0, 32'h44444444, 2'd3, 32'h0};
        tbl[2] = '{32'h010, 2'd3, 32'h0,        2'd3, 32'h0};
        tbl[3] = '{32'h006, 2'd2, 32'h0,        2'd2, 32'h0};
        tbl[4] = '{32'h0FC, 2'd3, 32'h0,        2'd3, 32'h0};
        tbl[5] = '{32'h104, 2'd3, 32'h0,        2'd0, 32'h22222222};
        tbl[6] = '{32'h10C, 2'd3, 32'h0,        2'd0, 32'h44444444};
        tbl[7] = '{32'h110, 2'd3, 32'h0,        2'd3, 32'h0};
        tbl[8] = '{32'h000, 2'd0, 32'h11111111, 2'd3, 32'h0};
        tbl[9] = '{32'h10E, 2'd2, 32'h0,        2'd2, 32'h0};

        for (int i = 0; i < 4; i++) begin
            bank_a[i] = 32'h11111111 * (i + 1);
            bank_b[i] = 32'h11111111 * (i + 1);
            bank_c[i] = 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0000_0101_0101_0101;
        end

        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_arready", k, 64'(arready_v[k]), 64'd0);
            chk("reset_rvalid", k, 64'(rvalid_v[k]), 64'd0);
            chk("reset_rdata", k, rdata_v[k], 64'd0);
            chk("reset_rresp", k, 64'(rresp_v[k]), 64'd0);
            chk("reset_strobe", k, 64'(strobe_v[k]), 64'd0);
            chk("reset_index", k, 64'(idx_v[k]), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_read(tbl[i].addr, 0, 1'b0, 1'b0);
            chk("tbl_resp_a", 0, 64'(cap_resp[0]), 64'(tbl[i].resp_a));
            chk("tbl_data_a", 0, cap_data[0], {32'h0, tbl[i].data_a});
            chk("tbl_resp_b", 1, 64'(cap_resp[1]), 64'(tbl[i].resp_b));
            chk("tbl_data_b", 1, cap_data[1], {32'h0, tbl[i].data_b});
        end

        // Backpressure with a snapshot-changing write and a blocked AR to 0x0
        do_read(32'h4, 5, 1'b1, 1'b1);
        chk("bp_snapshot_a", 0, cap_data[0], 64'h22222222);
        do_read(32'h0, 0, 1'b0, 1'b0);

        // Asynchronous reset while a response is pending
        araddr  = 32'h8;
        arvalid = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (arready_v[0] !== 1'b1 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("rst_ar_wait", 0, 64'(cyc < 20), 64'd1);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int w = 1; w < LAT; w++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_rvalid", 0, 64'(rvalid_v[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rvalid", k, 64'(rvalid_v[k]), 64'd0);
            chk("rst_arready", k, 64'(arready_v[k]), 64'd0);
            chk("rst_rdata", k, rdata_v[k], 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rel_arready_low", 0, 64'(arready_v[0]), 64'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) chk("rel_arready_high", k, 64'(arready_v[k]), 64'd1);
        do_read(32'h4, 1, 1'b0, 1'b0);

        // Randomised reads against the model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                bank_a[i] = $urandom;
                bank_b[i] = $urandom;
                bank_c[i] = {$urandom, $urandom};
            end
            case (sel)
                0:       a = $urandom_range(0, 32'h11F) & 32'hFFFF_FFFC;
                1:       a = $urandom_range(0, 32'h11F);
                2:       a = $urandom;
                default: a = 32'h100 + 32'd8 * $urandom_range(0, 5);
            endcase
            do_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axilite_read_slave.md
Name: axilite_read_slave

Overview:
Parametrised AXI4-Lite read-channel slave with a full AR and R handshake.
- Decodes byte addresses into a flat register bank of NUM_REGS words of DATA_WIDTH bits.
- Snapshots the addressed word and returns it with an OKAY, SLVERR or DECERR response.
- Sits between the interconnect and the coprocessor's status/result register bank; one outstanding read at a time.

Parameters:
DATA_WIDTH, 32, AXI data width in bits; must be 32 or 64.
ADDR_SIZE, 32, AXI address width in bits.
NUM_REGS, 4, number of readable words in the bank; at least 1.
BASE_ADDR, 0, byte address of word 0; aligned to DATA_WIDTH/8.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
reg_bank  in  NUM_REGS*DATA_WIDTH  flat register bank; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
araddr  in  ADDR_SIZE  read address (byte)
arvalid  in  1  address valid
arready  out  1  address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  response: 0 OKAY, 2 SLVERR, 3 DECERR
rvalid  out  1  response valid
rready  in  1  master ready for response
rd_index  out  clog2(NUM_REGS) (min 1)  index of the word whose AR was just accepted
rd_strobe  out  1  one-cycle pulse on each OKAY address acceptance

Behaviour:
- Reset values: arready=0, rvalid=0, rdata=0, rresp=0, rd_strobe=0, rd_index=0; state IDLE. All outputs are registered.
- States:
  - IDLE: arready=1. Entered on the first clk edge after rst deasserts.
  - FETCH: present only with AXIL_RD_PIPE_EN.
  - RESP: rvalid=1.
- IDLE to RESP (or FETCH) on arvalid&&arready at edge N:
  - arready drops at N+1.
  - Without the macro, rvalid=1 at N+1, so latency is 1 cycle.
- RESP:
  - rdata and rresp are held stable while rvalid=1 && !rready.
  - On rvalid&&rready: rvalid=0 and arready=1 at the next edge, then IDLE.
  - Minimum period is 2 cycles per read.
- Decode, evaluated on araddr at AR acceptance, with off = araddr - BASE_ADDR at ADDR_SIZE width, wrapping:
  - off[ADDR_LSB-1:0] != 0, where ADDR_LSB = log2(DATA_WIDTH/8): SLVERR, rdata=0.
  - araddr < BASE_ADDR, or off>>ADDR_LSB >= NUM_REGS: DECERR, rdata=0. Misalignment is checked first.
  - Otherwise: OKAY, rdata = word off>>ADDR_LSB.
- Snapshot: word is sampled at AR acceptance (or at the FETCH edge with the macro). Later reg_bank changes do not alter a pending rdata.
- rd_strobe/rd_index pulse for one cycle at the acceptance edge, OKAY reads only. Used for clear-on-read status bits.
- arvalid while in RESP is ignored (arready=0). The master holds it per AXI.
- rready while rvalid=0 has no effect.
- rst mid-transaction: immediate return to reset values; the pending response is discarded.
- Last valid word, off = (NUM_REGS-1)*DATA_WIDTH/8: OKAY. One word beyond: DECERR.

Optional Feature:
AXIL_RD_PIPE_EN
- Defined: FETCH state is inserted. Address decode is registered at acceptance, the word is selected at the next edge, rvalid rises at N+2. Eases timing for large NUM_REGS. rd_strobe timing is unchanged.
- Undefined: single-cycle latency as above; no FETCH state.

Decomposition:
- Package axilite_pkg holds:
  - RESP_OKAY=0, RESP_EXOKAY=1, RESP_SLVERR=2, RESP_DECERR=3.
  - State enum IDLE/FETCH/RESP.
  - clog2 helper function.
- One sub-module, axilite_addr_decode: combinational araddr to {index, resp}. Reusable by a future write-channel slave.

Test Plan:
- DATA_WIDTH=32, NUM_REGS=4, BASE_ADDR=0, reg_bank words 0..3 = 0x11111111..0x44444444; read 0x8 with rready=1 -> rvalid at N+1, rdata=0x33333333, rresp=0, rd_strobe pulse with rd_index=2, arready high again 2 cycles after acceptance.
- Read 0xC -> OKAY 0x44444444; read 0x10 -> DECERR, rdata=0, no rd_strobe; read 0x6 -> SLVERR, rdata=0.
- Backpressure: read 0x4, hold rready=0 for 5 cycles while changing word 1 to 0xDEADBEEF -> rdata stays 0x22222222 and rvalid stays 1; arvalid to 0x0 is not accepted until after the R handshake.
- BASE_ADDR=0x100: read 0xFC -> DECERR; read 0x104 -> word 1 OKAY.
- Assert rst while in RESP -> rvalid=0 and arready=0 immediately; arready=1 one edge after release; the next read completes normally.
- With AXIL_RD_PIPE_EN and DATA_WIDTH=64: read 0x8 -> rvalid at N+2, rdata = word 1; read 0x4 -> SLVERR.
